// File: rtl/intra_pkg.sv
// intra_pkg: constants and state encoding shared by the intra frame-row buffer logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package intra_pkg;

    // Row sequencer states: one INIT cycle, then a full-row CLEAR, then IDLE service.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } row_state_e;

    // Words per row and the value for an unavailable intra reference (mid-grey).
    localparam int          ROW_DEPTH_DEF = 480;
    localparam logic [31:0] FILL_WORD_DEF = 32'h80808080;

endpackage

// File: rtl/ram_frame_row_ctrl_if.sv
// ram_frame_row_ctrl_if: client-side handshake bundle (one writer, two readers).
// Latency: n/a (wires only).
// Backpressure: requests are held by the master until the matching ack.
interface ram_frame_row_ctrl_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [WORD_WIDTH-1:0] wr_data_i;
    logic                  wr_ack_o;

    logic                  rd0_req_i;
    logic [ADDR_WIDTH-1:0] rd0_addr_i;
    logic                  rd0_ack_o;
    logic                  rd0_valid_o;
    logic [WORD_WIDTH-1:0] rd0_data_o;

    logic                  rd1_req_i;
    logic [ADDR_WIDTH-1:0] rd1_addr_i;
    logic                  rd1_ack_o;
    logic                  rd1_valid_o;
    logic [WORD_WIDTH-1:0] rd1_data_o;

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, rd0_req_i, rd0_addr_i, rd1_req_i, rd1_addr_i,
        input  wr_ack_o, rd0_ack_o, rd0_valid_o, rd0_data_o, rd1_ack_o, rd1_valid_o, rd1_data_o
    );

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, rd0_req_i, rd0_addr_i, rd1_req_i, rd1_addr_i,
        output wr_ack_o, rd0_ack_o, rd0_valid_o, rd0_data_o, rd1_ack_o, rd1_valid_o, rd1_data_o
    );
endinterface

// File: rtl/ram_frame_row_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a registered priority pointer.
// Latency: combinational grant; pointer updates at the edge ending an accepted contended grant.
// Backpressure: a grant that is not accepted leaves the pointer untouched.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
    // ptr_q == 0 favours requester 0 on contention, 1 favours requester 1.
    logic ptr_q;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After serving one requester, hand priority to the other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept_i) begin
            ptr_q <= gnt_o[0];
        end
    end
endmodule

// File: rtl/ram_frame_row_ctrl.sv
// ram_frame_row_ctrl: frame-row RAM sequencer - row clear, writer on port A, two RR readers on port B.
// Latency: write acked in the RAM write cycle; read data valid 2 cycles after ack.
// Backpressure: no acks while busy; one read grant per cycle; FRAME_ROW_FWD_EN forwards colliding reads, else they stall one cycle.
module ram_frame_row_ctrl
    import intra_pkg::*;
#(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    ROW_DEPTH  = ROW_DEPTH_DEF,
    parameter logic [WORD_WIDTH-1:0] FILL_WORD  = FILL_WORD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  err_o,
    ram_frame_row_ctrl_if.slave   bus,
    output logic                  ram_cena_o,
    output logic                  ram_wena_o,
    output logic                  ram_oena_o,
    output logic [ADDR_WIDTH-1:0] ram_addra_o,
    output logic [WORD_WIDTH-1:0] ram_dataa_o,
    output logic                  ram_cenb_o,
    output logic                  ram_wenb_o,
    output logic                  ram_oenb_o,
    output logic [ADDR_WIDTH-1:0] ram_addrb_o,
    input  logic [WORD_WIDTH-1:0] ram_datab_i
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_DEPTH - 1);

    row_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q, err_q;

    logic                  idle, wr_in, rd_in, coll, fwd, rd_go, rd_ram, err_d, arb_accept, sel;
    logic [1:0]            req, gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // Read pipeline: stage p_* spans the RAM access cycle, rdN_data_q is the capture register.
    logic                  p_vld_q, p_id_q, p_ram_q;
    logic [WORD_WIDTH-1:0] p_word_q, cap_word_d;
    logic [WORD_WIDTH-1:0] rd0_data_q, rd1_data_q;
    logic [1:0]            rd_vld_q;

    assign idle  = (state_q == ST_IDLE);
    assign wr_in = (bus.wr_addr_i <= LAST_ADDR);
    assign req   = {bus.rd1_req_i, bus.rd0_req_i} & {2{idle}};

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .accept_i (arb_accept),
        .gnt_o    (gnt)
    );

    assign sel      = gnt[1];
    assign sel_addr = sel ? bus.rd1_addr_i : bus.rd0_addr_i;
    assign rd_in    = (sel_addr <= LAST_ADDR);
    assign coll     = (|gnt) && idle && bus.wr_req_i && rd_in && (sel_addr == bus.wr_addr_i);

`ifdef FRAME_ROW_FWD_EN
    // Colliding read takes the write data directly instead of racing the RAM write.
    assign fwd   = coll;
    assign rd_go = |gnt;
`else
    // Colliding read waits a cycle so it sees the freshly written word.
    assign fwd   = 1'b0;
    assign rd_go = (|gnt) && !coll;
`endif

    assign arb_accept = rd_go && (&req);
    assign rd_ram     = rd_go && rd_in && !fwd;
    assign err_d      = idle && ((bus.wr_req_i && !wr_in) || (rd_go && !rd_in));

    assign bus.wr_ack_o  = idle && bus.wr_req_i;
    assign bus.rd0_ack_o = rd_go && !sel;
    assign bus.rd1_ack_o = rd_go && sel;

    assign busy_o = busy_q;
    assign err_o  = err_q;

    // Port A: clear sweep while clearing, otherwise the in-range writer.
    always_comb begin
        ram_cena_o  = 1'b1;
        ram_wena_o  = 1'b1;
        ram_addra_o = '0;
        ram_dataa_o = '0;
        if (state_q == ST_CLEAR) begin
            ram_cena_o  = 1'b0;
            ram_wena_o  = 1'b0;
            ram_addra_o = cnt_q;
            ram_dataa_o = FILL_WORD;
        end else if (idle && bus.wr_req_i && wr_in) begin
            ram_cena_o  = 1'b0;
            ram_wena_o  = 1'b0;
            ram_addra_o = bus.wr_addr_i;
            ram_dataa_o = bus.wr_data_i;
        end
    end

    assign ram_oena_o  = 1'b1;
    assign ram_cenb_o  = !rd_ram;
    assign ram_wenb_o  = 1'b1;
    assign ram_oenb_o  = 1'b0;
    assign ram_addrb_o = rd_ram ? sel_addr : '0;

    // Row sequencer: INIT -> CLEAR sweep -> IDLE; clr_i restarts the sweep and drops the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            if (err_d) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM output is only defined in the cycle after a read, so substitute words come from p_word_q.
    assign cap_word_d = p_ram_q ? ram_datab_i : p_word_q;

    // Two-stage read pipeline; in-flight reads finish regardless of clr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld_q    <= 1'b0;
            p_id_q     <= 1'b0;
            p_ram_q    <= 1'b0;
            p_word_q   <= '0;
            rd_vld_q   <= '0;
            rd0_data_q <= '0;
            rd1_data_q <= '0;
        end else begin
            p_vld_q  <= rd_go;
            p_id_q   <= sel;
            p_ram_q  <= rd_ram;
            p_word_q <= fwd ? bus.wr_data_i : FILL_WORD;
            rd_vld_q <= '0;
            if (p_vld_q) begin
                if (p_id_q) begin
                    rd_vld_q[1] <= 1'b1;
                    rd1_data_q  <= cap_word_d;
                end else begin
                    rd_vld_q[0] <= 1'b1;
                    rd0_data_q  <= cap_word_d;
                end
            end
        end
    end

    assign bus.rd0_valid_o = rd_vld_q[0];
    assign bus.rd1_valid_o = rd_vld_q[1];
    assign bus.rd0_data_o  = rd0_data_q;
    assign bus.rd1_data_o  = rd1_data_q;
endmodule
